// File: rtl/bf_pkg.sv
// Shared Bellman-Ford definitions: checker FSM states, default memory geometry
// and the unreachable-distance encoding.
// Imported by the result checker and the SRAM models.
package bf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } bf_state_e;

  localparam int BF_ADDR_W = 13;
  localparam int BF_DATA_W = 16;
  localparam int BF_DEPTH  = 8192;

  // All-ones value of the given width (callers truncate to their word width).
  function automatic logic [63:0] inf_val(input int w);
    logic [63:0] v;
    v = '1;
    if (w < 64) v = (64'd1 << w) - 64'd1;
    return v;
  endfunction

endpackage

// File: rtl/bf_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// One-cycle update; synchronous clear has priority over increment.
// No flow control; increments are accepted every cycle.
module bf_sat_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bf_result_checker.sv
// Post-Finish result unloader: streams every output-memory entry and compares it with golden.
// One record per cycle with out_ready high; DEPTH records take DEPTH cycles from SCAN entry.
// Address, valid and last hold until out_valid&out_ready; the scan stalls in place.
module bf_result_checker
  import bf_pkg::*;
#(
  parameter int                ADDR_W  = BF_ADDR_W,
  parameter int                DATA_W  = BF_DATA_W,
  parameter int                DEPTH   = BF_DEPTH,
  parameter logic [DATA_W-1:0] INF_VAL = DATA_W'(inf_val(DATA_W)),
  parameter bit                CMP_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Finish,
  input  logic              NegCycle,
  input  logic              expect_neg,
  output logic [ADDR_W-1:0] OMAR,
  input  logic [DATA_W-1:0] OMDR,
  output logic [ADDR_W-1:0] GAR,
  input  logic [DATA_W-1:0] GDR,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_inf,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              neg_seen,
  output logic [ADDR_W:0]   mismatch_cnt,
  output logic [ADDR_W-1:0] first_bad_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bf_state_e         state_q, state_d;
  logic              finish_q;
  logic [ADDR_W-1:0] omar_q, omar_d;
  logic [ADDR_W-1:0] first_bad_q, first_bad_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              neg_seen_q, neg_seen_d;

  logic              run_start;
  logic              in_scan;
  logic              hs;
  logic              cnt_inc;
  logic              any_mis;
  logic              pass_rule;
  logic [ADDR_W:0]   cnt;

  // finish_q resets high so a Finish level already present out of reset is not an edge.
  assign run_start = Finish && !finish_q && (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_scan   = (state_q == ST_SCAN);
  assign hs        = in_scan && out_ready;
  assign cnt_inc   = hs && CMP_EN && (OMDR != GDR);
  // Include this cycle's mismatch so the last record is judged before the count updates.
  assign any_mis   = (cnt != '0) || cnt_inc;
  assign pass_rule = (neg_seen_q == expect_neg) && (!CMP_EN || neg_seen_q || !any_mis);

  bf_sat_counter #(
    .W (ADDR_W + 1)
  ) u_mis_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (run_start),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  // Run sequencing: start from idle/done, walk addresses on handshakes, latch the verdict.
  always_comb begin
    state_d     = state_q;
    omar_d      = omar_q;
    first_bad_d = first_bad_q;
    done_d      = done_q;
    pass_d      = pass_q;
    neg_seen_d  = neg_seen_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run_start) begin
          done_d      = 1'b0;
          pass_d      = 1'b0;
          first_bad_d = '0;
          neg_seen_d  = NegCycle;
          omar_d      = '0;
          state_d     = NegCycle ? ST_NEG : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hs) begin
          if (cnt_inc && (cnt == '0)) first_bad_d = omar_q;
          if (omar_q == LAST_ADDR) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = pass_rule;
          end else begin
            omar_d = omar_q + 1'b1;
          end
        end
      end
      ST_NEG: begin
        // Distances are undefined with a negative cycle: no traffic, no compare.
        state_d = ST_DONE;
        done_d  = 1'b1;
        pass_d  = pass_rule;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      finish_q    <= 1'b1;
      omar_q      <= '0;
      first_bad_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      neg_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      finish_q    <= Finish;
      omar_q      <= omar_d;
      first_bad_q <= first_bad_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      neg_seen_q  <= neg_seen_d;
    end
  end

  assign OMAR           = omar_q;
  assign GAR            = omar_q;
  assign out_valid      = in_scan;
  assign out_addr       = omar_q;
  // Stream payload is the combinational SRAM word, zeroed while no record is offered.
  assign out_data       = in_scan ? OMDR : '0;
  assign out_inf        = in_scan && (OMDR == INF_VAL);
  assign out_last       = in_scan && (omar_q == LAST_ADDR);
  assign busy           = in_scan || (state_q == ST_NEG);
  assign done           = done_q;
  assign pass           = pass_q;
  assign neg_seen       = neg_seen_q;
  assign mismatch_cnt   = cnt;
  assign first_bad_addr = first_bad_q;

endmodule

// File: tb/tb_bf_result_checker.sv
// Bench for bf_result_checker: directed and random runs against a scan-level model.
// Stream records are checked at every negedge handshake; results checked at done.
// Includes a small-geometry instance and a standalone saturating-counter instance.
module tb_bf_result_checker;

  logic        clock;
  logic        reset;
  logic        Finish, NegCycle, expect_neg;
  logic [2:0]  OMAR, GAR, out_addr, first_bad_addr;
  logic [15:0] OMDR, GDR, out_data;
  logic        out_valid, out_ready, out_inf, out_last, busy, done, pass, neg_seen;
  logic [3:0]  mismatch_cnt;

  logic [15:0] omem [8];
  logic [15:0] gmem [8];

  assign OMDR = omem[OMAR];
  assign GDR  = gmem[GAR];

  bf_result_checker #(.ADDR_W(3), .DATA_W(16), .DEPTH(8), .CMP_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .Finish(Finish), .NegCycle(NegCycle),
    .expect_neg(expect_neg), .OMAR(OMAR), .OMDR(OMDR), .GAR(GAR), .GDR(GDR),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_inf(out_inf), .out_last(out_last), .busy(busy),
    .done(done), .pass(pass), .neg_seen(neg_seen), .mismatch_cnt(mismatch_cnt),
    .first_bad_addr(first_bad_addr)
  );

  // Small instance: 4 entries, used for the all-mismatch count.
  logic        f2, r2, v2, inf2, last2, busy2, done2, pass2, ns2;
  logic [1:0]  omar2, gar2, addr2, fb2;
  logic [15:0] omdr2, gdr2, data2;
  logic [2:0]  cnt2;
  logic [15:0] omem2 [4];
  logic [15:0] gmem2 [4];

  assign omdr2 = omem2[omar2];
  assign gdr2  = gmem2[gar2];

  bf_result_checker #(.ADDR_W(2), .DATA_W(16), .DEPTH(4), .CMP_EN(1'b1)) dut2 (
    .clock(clock), .reset(reset), .Finish(f2), .NegCycle(1'b0),
    .expect_neg(1'b0), .OMAR(omar2), .OMDR(omdr2), .GAR(gar2), .GDR(gdr2),
    .out_valid(v2), .out_ready(r2), .out_addr(addr2),
    .out_data(data2), .out_inf(inf2), .out_last(last2), .busy(busy2),
    .done(done2), .pass(pass2), .neg_seen(ns2), .mismatch_cnt(cnt2),
    .first_bad_addr(fb2)
  );

  logic       sc_clr, sc_inc;
  logic [2:0] sc_cnt;

  bf_sat_counter #(.W(3)) u_sc (
    .clock(clock), .reset(reset), .clr(sc_clr), .inc(sc_inc), .cnt(sc_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;
  int exp_idx = 0;
  int rec_cnt = 0;
  int inf_addr = -1;
  int rdy_mode = 0;
  int rcyc = 0;
  bit prev_stall = 0;
  logic [2:0]  prev_addr;
  logic [15:0] prev_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Ready driver: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        1:       out_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      rcyc++;
    end
  end

  // Stream compare: every handshake must carry the next address of the scan.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 0;
    end else if (out_valid) begin
      if (prev_stall) begin
        chk("hold_addr", 32'(out_addr), 32'(prev_addr));
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_ready) begin
        chk("rec_addr", 32'(out_addr), 32'(exp_idx));
        chk("rec_omar", 32'(GAR), 32'(exp_idx));
        chk("rec_data", 32'(out_data), 32'(omem[3'(exp_idx)]));
        chk("rec_inf", 32'(out_inf), 32'(omem[3'(exp_idx)] == 16'hFFFF));
        chk("rec_last", 32'(out_last), 32'(exp_idx == 7));
        if (out_inf && inf_addr < 0) inf_addr = int'(out_addr);
        exp_idx++;
        rec_cnt++;
      end
      prev_stall = !out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic do_run(input bit neg, input bit exn, input int mode, input bit pulse_mid);
    int  ecnt, efirst, cyc;
    bit  epass, got;
    ecnt = 0;
    efirst = 0;
    if (!neg) begin
      for (int a = 0; a < 8; a++) begin
        if (omem[a] != gmem[a]) begin
          if (ecnt == 0) efirst = a;
          ecnt++;
        end
      end
    end
    epass = (neg == exn) && (neg || ecnt == 0);
    Finish = 1'b0;
    NegCycle = neg;
    expect_neg = exn;
    rdy_mode = mode;
    repeat (2) @(posedge clock);
    #1;
    exp_idx = 0;
    rec_cnt = 0;
    inf_addr = -1;
    Finish = 1'b1;
    got = 0;
    cyc = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (cyc == 1) chk("start_clears_done", 32'(done), 32'd0);
      if (pulse_mid && cyc == 4) Finish = 1'b0;
      if (pulse_mid && cyc == 5) Finish = 1'b1;
      if (done) got = 1;
    end
    chk("done_reached", 32'(got), 32'd1);
    if (mode == 0) chk("latency", 32'(cyc), neg ? 32'd2 : 32'd9);
    chk("records", 32'(rec_cnt), neg ? 32'd0 : 32'd8);
    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(ecnt));
    chk("first_bad_addr", 32'(first_bad_addr), 32'(efirst));
    chk("pass", 32'(pass), 32'(epass));
    chk("neg_seen", 32'(neg_seen), 32'(neg));
    chk("busy_done", 32'(busy), 32'd0);
    chk("valid_done", 32'(out_valid), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("done_held", 32'(done), 32'd1);
    chk("no_rerun", 32'(rec_cnt), neg ? 32'd0 : 32'd8);
  endtask

  initial begin
    bit got;
    reset = 1'b1;
    Finish = 1'b1;
    NegCycle = 1'b0;
    expect_neg = 1'b0;
    f2 = 1'b0;
    r2 = 1'b1;
    sc_clr = 1'b0;
    sc_inc = 1'b0;
    for (int a = 0; a < 8; a++) begin
      omem[a] = 16'(a * 5);
      gmem[a] = 16'(a * 5);
    end
    for (int a = 0; a < 4; a++) begin
      omem2[a] = 16'(a);
      gmem2[a] = 16'(a + 100);
    end
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_omar", 32'(OMAR), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(mismatch_cnt), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("finish_high_no_start", 32'(busy), 32'd0);
    chk("finish_high_no_valid", 32'(out_valid), 32'd0);

    // Identical memories with an INF entry.
    omem = '{16'd0, 16'd3, 16'hFFFF, 16'd7, 16'd9, 16'd11, 16'd13, 16'd15};
    gmem = omem;
    do_run(0, 0, 0, 0);
    chk("t1_inf_addr", 32'(inf_addr), 32'd2);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_cnt", 32'(mismatch_cnt), 32'd0);

    // Entries 3 and 5 differ.
    gmem[3] = 16'd8;
    gmem[5] = 16'hFFFF;
    do_run(0, 0, 0, 0);
    chk("t2_cnt", 32'(mismatch_cnt), 32'd2);
    chk("t2_first", 32'(first_bad_addr), 32'd3);
    chk("t2_pass", 32'(pass), 32'd0);

    // Backpressure 1,0,0,1 with an ignored Finish pulse mid-scan.
    do_run(0, 0, 1, 1);

    // Negative cycle, agreed and disagreed.
    do_run(1, 1, 0, 0);
    chk("t4_pass", 32'(pass), 32'd1);
    do_run(1, 0, 0, 0);
    chk("t4b_pass", 32'(pass), 32'd0);

    // Reset during a scan after four records.
    Finish = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    exp_idx = 0;
    rec_cnt = 0;
    NegCycle = 1'b0;
    Finish = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(posedge clock);
      #1;
      if (rec_cnt >= 4) got = 1;
    end
    chk("t5_reached_rec4", 32'(got), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_omar", 32'(OMAR), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cnt", 32'(mismatch_cnt), 32'd0);
    chk("t5_last", 32'(out_last), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_idx = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("t5_idle_after", 32'(busy), 32'd0);
    do_run(0, 0, 0, 0);
    chk("t5_rescan_cnt", 32'(mismatch_cnt), 32'd2);

    // Random runs.
    for (int r = 0; r < 10; r++) begin
      bit dirty, neg, exn;
      dirty = 1'($urandom_range(0, 1));
      for (int a = 0; a < 8; a++) begin
        omem[a] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 500));
        gmem[a] = omem[a];
        if (dirty && $urandom_range(0, 2) == 0)
          gmem[a] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : omem[a] + 16'd1;
        if (gmem[a] == omem[a] && dirty && a == 6) gmem[a] = omem[a] ^ 16'h0100;
      end
      neg = ($urandom_range(0, 3) == 0);
      exn = ($urandom_range(0, 4) == 0) ? !neg : neg;
      do_run(neg, exn, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Small instance, every entry differs.
    @(posedge clock);
    #1;
    f2 = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(posedge clock);
      #1;
      if (done2) got = 1;
    end
    chk("d2_done", 32'(got), 32'd1);
    chk("d2_cnt", 32'(cnt2), 32'd4);
    chk("d2_first", 32'(fb2), 32'd0);
    chk("d2_pass", 32'(pass2), 32'd0);

    // Saturating counter run well past its ceiling.
    sc_inc = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("sc_five", 32'(sc_cnt), 32'd5);
    repeat (5) @(posedge clock);
    #1;
    chk("sc_sat", 32'(sc_cnt), 32'd7);
    sc_clr = 1'b1;
    @(posedge clock);
    #1;
    chk("sc_clr_wins", 32'(sc_cnt), 32'd0);
    sc_clr = 1'b0;
    sc_inc = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bf_result_checker.md
Name: bf_result_checker

Overview:
- Synthesizable result unloader/checker that runs after the Bellman-Ford core asserts Finish.
- Walks the output-distance SRAM, streams every entry out over a valid/ready port, and compares each entry against a golden-distance SRAM.
- Reports pass/fail, mismatch count, first failing address and negative-cycle agreement.
- Generalises the current dump-on-Finish bench flow: parametrised width/depth, backpressure, compare mode, runs in hardware or simulation.

Parameters:
- ADDR_W, 13, address width of output and golden memories.
- DATA_W, 16, distance word width.
- DEPTH, 8192, entries scanned (1..2^ADDR_W).
- INF_VAL, all-ones of DATA_W, encoding of unreachable distance.
- CMP_EN, 1, 1 = compare against golden; 0 = dump only (pass ignores data).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- Finish  in  1  core completion level.
- NegCycle  in  1  core negative-cycle flag; valid while Finish=1.
- expect_neg  in  1  golden negative-cycle expectation.
- OMAR  out  ADDR_W  output-memory read address.
- OMDR  in  DATA_W  output-memory read data (combinational read of OMAR).
- GAR  out  ADDR_W  golden-memory read address (always equals OMAR).
- GDR  in  DATA_W  golden-memory read data (combinational).
- out_valid  out  1  stream record valid.
- out_ready  in  1  stream consumer ready.
- out_addr  out  ADDR_W  record address.
- out_data  out  DATA_W  record distance.
- out_inf  out  1  out_data == INF_VAL.
- out_last  out  1  final record (addr == DEPTH-1).
- busy  out  1  scan in progress.
- done  out  1  result valid; held until next run or reset.
- pass  out  1  run passed; valid when done=1.
- neg_seen  out  1  NegCycle was sampled at start.
- mismatch_cnt  out  ADDR_W+1  number of mismatching entries, saturating.
- first_bad_addr  out  ADDR_W  address of first mismatch; 0 if none.

Behaviour:
- Reset values: all outputs 0, including OMAR, counters and state=IDLE. Reset is async and takes effect mid-scan with no completion.
- Start event: rising edge of Finish, detected via a registered Finish_q. Finish already high out of reset does not start a run.
- FSM states: IDLE, SCAN, NEG, DONE.
- IDLE or DONE + start:
  - Clear mismatch_cnt, first_bad_addr, done and pass.
  - Latch neg_seen = NegCycle.
  - If NegCycle=1, go to NEG; else go to SCAN with OMAR=0.
- Start while in SCAN or NEG is ignored.
- SCAN:
  - busy=1, out_valid=1.
  - out_addr=OMAR, out_data=OMDR, out_inf=(OMDR==INF_VAL), out_last=(OMAR==DEPTH-1).
  - Stream data is combinational from the SRAM; address, valid and last are registered or state-derived.
  - Handshake on out_valid&out_ready.
  - Without handshake, OMAR and all outputs hold stable (AXI-style: valid never drops without a handshake).
- On handshake, when CMP_EN=1 and OMDR != GDR:
  - mismatch_cnt increments, saturating at 2^(ADDR_W+1)-1.
  - If this is the first mismatch, first_bad_addr=OMAR.
  - INF_VAL vs INF_VAL counts as a match.
- On a handshake with out_last=1, go to DONE; otherwise OMAR+1.
- Throughput: 1 record/cycle with out_ready held high. DEPTH records take exactly DEPTH cycles from entering SCAN.
- NEG:
  - One cycle, no stream traffic, then DONE.
  - Golden data is not compared (distances are undefined).
- DONE:
  - done=1, busy=0, out_valid=0.
  - pass = (neg_seen==expect_neg) && (CMP_EN==0 || neg_seen==1 || mismatch_cnt==0).
  - expect_neg is sampled at the DONE entry and latched into pass.
- Finish falling then rising again from DONE starts a fresh run.
- DEPTH=1: first record is also last; SCAN lasts one handshake.

Decomposition:
- Package bf_pkg:
  - FSM state enum.
  - Default ADDR_W/DATA_W/DEPTH constants shared with bellmanford and the SRAM models.
  - INF_VAL helper function returning all-ones of a width.
- One natural sub-module: bf_sat_counter (parametrised width, increment, sync clear, async reset) for mismatch_cnt.
- All else is inline in bf_result_checker.

Test Plan:
- Dump, identical memories: DEPTH=8, ready=1, out=golden={0,3,FFFF,7,...}, Finish rises at t0.
  - Expect 8 records addr 0..7 in consecutive cycles, out_last on addr 7, out_inf on addr 2.
  - Expect done=1, pass=1, mismatch_cnt=0.
- Mismatch: entries 3 and 5 differ; expect mismatch_cnt=2, first_bad_addr=3, pass=0.
- Backpressure: ready toggles 1,0,0,1 pattern; expect OMAR/out_data stable while ready=0, no record lost or duplicated, total 8 records.
- Negative cycle: NegCycle=1 at Finish rise.
  - expect_neg=1: zero records, done within 2 cycles, neg_seen=1, pass=1.
  - Repeat with expect_neg=0: pass=0.
- Reset mid-scan: assert reset at record 4; expect all outputs 0 asynchronously, then IDLE.
  - A new Finish edge then rescans from addr 0 with clean counters.
- Restart and saturation:
  - Finish pulse during SCAN is ignored.
  - ADDR_W=2, DEPTH=4, all entries mismatched: mismatch_cnt=4.
  - Counter saturation is checked with forced near-max count.
